vga_timing_gen: RTL and testbench

- Raster timing generator for the VGA display path. It sits directly upstream of the VGA controller.
- Produces the raw pixel column/row counters, active-low sync pulses and a blanking flag for 640x480@60 (25.175 MHz pixel clock).
- Also produces per-line and per-frame strobes, plus a cursor blink phase used by the text-mode cursor logic.
- Downstream stages subtract the 40-line border themselves; this block emits raw raster coordinates.

---
 rtl/vga_timing_pkg.sv | 20 ++
 rtl/vga_axis_counter.sv | 56 +++++
 rtl/vga_timing_gen.sv | 106 ++++++++++
 tb/tb_vga_timing_gen.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and coordinate type for the VGA path.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_timing_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int H_FP         = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BP         = 48;
  localparam int V_ACTIVE     = 480;
  localparam int V_FP         = 10;
  localparam int V_SYNC       = 2;
  localparam int V_BP         = 33;
  localparam int BLINK_FRAMES = 16;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef logic [9:0] vga_coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with sync and blank decoded
// from the next count so they line up with the count they describe.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE,
  parameter int FP     = H_FP,
  parameter int SYNC   = H_SYNC,
  parameter int BP     = H_BP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  output vga_coord_t count,
  output logic       sync_n,
  output logic       blank,
  output logic       wrap
);

  localparam vga_coord_t ACT_END  = vga_coord_t'(ACTIVE);
  localparam vga_coord_t SYNC_BEG = vga_coord_t'(ACTIVE + FP);
  localparam vga_coord_t SYNC_END = vga_coord_t'(ACTIVE + FP + SYNC);
  localparam vga_coord_t LAST     = vga_coord_t'(ACTIVE + FP + SYNC + BP - 1);

  vga_coord_t count_q, count_d;
  logic       sync_n_q;
  logic       blank_q;

  assign wrap   = advance && (count_q == LAST);
  assign count  = count_q;
  assign sync_n = sync_n_q;
  assign blank  = blank_q;

  // next count: hold, step, or wrap to zero at the last position
  always_comb begin
    count_d = count_q;
    if (wrap)
      count_d = '0;
    else if (advance)
      count_d = count_q + 10'd1;
  end

  // register count plus sync/blank decoded from the next count
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      sync_n_q <= 1'b1;
      blank_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      sync_n_q <= !((count_d >= SYNC_BEG) && (count_d < SYNC_END));
      blank_q  <= (count_d >= ACT_END);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: col/row, active-low syncs, blank, strobes, blink.
// Optional cursor blink counter enabled by VGA_CURSOR_BLINK_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE     = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP         = vga_timing_pkg::H_FP,
  parameter int H_SYNC       = vga_timing_pkg::H_SYNC,
  parameter int H_BP         = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE     = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP         = vga_timing_pkg::V_FP,
  parameter int V_SYNC       = vga_timing_pkg::V_SYNC,
  parameter int V_BP         = vga_timing_pkg::V_BP,
  parameter int BLINK_FRAMES = vga_timing_pkg::BLINK_FRAMES
) (
  input  logic       clk,
  input  logic       reset,
  output vga_coord_t col,
  output vga_coord_t row,
  output logic       hsync,
  output logic       vsync,
  output logic       is_blank,
  output logic       line_start,
  output logic       frame_start,
  output logic       blink
);

  if (BLINK_FRAMES < 1 || BLINK_FRAMES > 32) begin : g_bad_blink
    $error("BLINK_FRAMES must be within 1..32");
  end

  logic h_wrap, v_wrap;
  logic h_blank, v_blank;
  logic ls_q, fs_q;
  logic frame_tick;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h (
    .clk    (clk),
    .reset  (reset),
    .advance(1'b1),
    .count  (col),
    .sync_n (hsync),
    .blank  (h_blank),
    .wrap   (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v (
    .clk    (clk),
    .reset  (reset),
    .advance(h_wrap),
    .count  (row),
    .sync_n (vsync),
    .blank  (v_blank),
    .wrap   (v_wrap)
  );

  assign frame_tick  = !reset && h_wrap && v_wrap;
  assign is_blank    = h_blank | v_blank;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

  // strobes mark the cycle the counters land on col 0 / (0,0)
  always_ff @(posedge clk) begin
    if (reset) begin
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      ls_q <= h_wrap;
      fs_q <= h_wrap && v_wrap;
    end
  end

`ifdef VGA_CURSOR_BLINK_EN
  localparam logic [4:0] BLINK_LAST = 5'(BLINK_FRAMES - 1);

  logic [4:0] frm_q;
  logic       blink_q;

  assign blink = blink_q;

  // count frames; flip the blink phase every BLINK_FRAMES frames
  always_ff @(posedge clk) begin
    if (reset) begin
      frm_q   <= '0;
      blink_q <= 1'b0;
    end else if (frame_tick) begin
      if (frm_q == BLINK_LAST) begin
        frm_q   <= '0;
        blink_q <= ~blink_q;
      end else begin
        frm_q <= frm_q + 5'd1;
      end
    end
  end
`else
  logic unused_tick;

  assign unused_tick = frame_tick;
  assign blink       = 1'b1;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: default-geometry DUT for line timing, small
// geometry DUT for frame, vsync, reset and blink behaviour.
module tb_vga_timing_gen;

  localparam int SHA = 40;
  localparam int SHF = 4;
  localparam int SHS = 6;
  localparam int SHB = 10;
  localparam int SVA = 30;
  localparam int SVF = 3;
  localparam int SVS = 2;
  localparam int SVB = 5;
  localparam int SBF = 2;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SFR = SHT * (SVA + SVF + SVS + SVB);

`ifdef VGA_CURSOR_BLINK_EN
  localparam logic BK_RST = 1'b0;
`else
  localparam logic BK_RST = 1'b1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_f = 1'b1;
  logic rst_s = 1'b1;

  logic [9:0] col_f, row_f, col_s, row_s;
  logic hs_f, vs_f, bl_f, ls_f, fs_f, bk_f;
  logic hs_s, vs_s, bl_s, ls_s, fs_s, bk_s;

  int errors = 0;
  int checks = 0;
  int t_f = 0;
  int t_s = 0;

  logic [25:0] obs_f, obs_s;
  assign obs_f = {col_f, row_f, hs_f, vs_f, bl_f, ls_f, fs_f, bk_f};
  assign obs_s = {col_s, row_s, hs_s, vs_s, bl_s, ls_s, fs_s, bk_s};

  vga_timing_gen u_full (
    .clk        (clk),
    .reset      (rst_f),
    .col        (col_f),
    .row        (row_f),
    .hsync      (hs_f),
    .vsync      (vs_f),
    .is_blank   (bl_f),
    .line_start (ls_f),
    .frame_start(fs_f),
    .blink      (bk_f)
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .BLINK_FRAMES(SBF)
  ) u_small (
    .clk        (clk),
    .reset      (rst_s),
    .col        (col_s),
    .row        (row_s),
    .hsync      (hs_s),
    .vsync      (vs_s),
    .is_blank   (bl_s),
    .line_start (ls_s),
    .frame_start(fs_s),
    .blink      (bk_s)
  );

  // cycles elapsed since each DUT last sampled reset high
  always @(posedge clk) begin
    t_f <= rst_f ? 0 : t_f + 1;
    t_s <= rst_s ? 0 : t_s + 1;
  end

  // raster position and outputs as a pure function of elapsed time
  function automatic logic [25:0] model(int t, int ha, int hf, int hs,
                                        int hb, int va, int vf, int vs,
                                        int vb, int bf);
    int ht, vt, c, r, f;
    logic h, v, b, ls, fs, bk;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    c  = t % ht;
    r  = (t / ht) % vt;
    f  = t / (ht * vt);
    h  = !(c >= ha + hf && c < ha + hf + hs);
    v  = !(r >= va + vf && r < va + vf + vs);
    b  = (c >= ha) || (r >= va);
    ls = (t > 0) && (c == 0);
    fs = ls && (r == 0);
`ifdef VGA_CURSOR_BLINK_EN
    bk = ((f / bf) % 2) == 1;
`else
    bk = 1'b1;
`endif
    return {c[9:0], r[9:0], h, v, b, ls, fs, bk};
  endfunction

  function automatic logic [25:0] mf(int t);
    return model(t, 640, 16, 96, 48, 480, 10, 2, 33, 16);
  endfunction

  function automatic logic [25:0] ms(int t);
    return model(t, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, SBF);
  endfunction

  task automatic test_reset();
    logic [25:0] exp;
    exp = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, BK_RST};
    rst_f = 1'b1;
    rst_s = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs_f !== exp) begin
      errors++;
      $display("FAIL reset_full got=%h exp=%h", obs_f, exp);
    end
    checks++;
    if (obs_s !== exp) begin
      errors++;
      $display("FAIL reset_small got=%h exp=%h", obs_s, exp);
    end
  endtask

  task automatic test_hline();
    @(posedge clk);
    #1 rst_f = 1'b0;
    for (int i = 0; i < 1700; i++) begin
      @(negedge clk);
      checks++;
      if (obs_f !== mf(t_f)) begin
        errors++;
        if (errors <= 40)
          $display("FAIL hline t=%0d got=%h exp=%h", t_f, obs_f, mf(t_f));
      end
      if (t_f == 656) begin
        checks++;
        if (col_f !== 10'd656 || hs_f !== 1'b0) begin
          errors++;
          $display("FAIL hsync_fall col=%0d hs=%b exp 656/0", col_f, hs_f);
        end
      end
      if (t_f == 752) begin
        checks++;
        if (col_f !== 10'd752 || hs_f !== 1'b1) begin
          errors++;
          $display("FAIL hsync_rise col=%0d hs=%b exp 752/1", col_f, hs_f);
        end
      end
      if (t_f == 639 || t_f == 640) begin
        checks++;
        if (bl_f !== (t_f == 640) || row_f !== 10'd0) begin
          errors++;
          $display("FAIL blank_edge t=%0d bl=%b row=%0d", t_f, bl_f, row_f);
        end
      end
      if (t_f == 800 || t_f == 801) begin
        checks++;
        if (row_f !== 10'd1 || ls_f !== (t_f == 800)) begin
          errors++;
          $display("FAIL line_start t=%0d row=%0d ls=%b", t_f, row_f, ls_f);
        end
      end
    end
  endtask

  task automatic test_frames();
    int last_fs, nfs, vrun;
    logic exp_bk;
    last_fs = -1;
    nfs = 0;
    vrun = 0;
    @(posedge clk);
    #1 rst_s = 1'b0;
    for (int i = 0; i < 5 * SFR + 20; i++) begin
      @(negedge clk);
      checks++;
      if (obs_s !== ms(t_s)) begin
        errors++;
        if (errors <= 40)
          $display("FAIL frame t=%0d got=%h exp=%h", t_s, obs_s, ms(t_s));
      end
      if (vs_s === 1'b0) begin
        vrun++;
        checks++;
        if (bl_s !== 1'b1) begin
          errors++;
          $display("FAIL vsync_blank t=%0d bl=%b exp=1", t_s, bl_s);
        end
      end else if (vrun > 0) begin
        checks++;
        if (vrun != 2 * SHT) begin
          errors++;
          $display("FAIL vsync_len got=%0d exp=%0d", vrun, 2 * SHT);
        end
        vrun = 0;
      end
      if (fs_s === 1'b1) begin
        nfs++;
        if (last_fs >= 0) begin
          checks++;
          if (i - last_fs != SFR) begin
            errors++;
            $display("FAIL fs_gap got=%0d exp=%0d", i - last_fs, SFR);
          end
        end
        last_fs = i;
`ifdef VGA_CURSOR_BLINK_EN
        exp_bk = ((nfs / 2) % 2) == 1;
`else
        exp_bk = 1'b1;
`endif
        checks++;
        if (bk_s !== exp_bk || col_s !== 10'd0 || row_s !== 10'd0) begin
          errors++;
          $display("FAIL fs_blink n=%0d bk=%b exp=%b", nfs, bk_s, exp_bk);
        end
      end
    end
    checks++;
    if (nfs != 5) begin
      errors++;
      $display("FAIL fs_count got=%0d exp=5", nfs);
    end
  endtask

  task automatic test_midframe_reset();
    int n;
    logic found;
    found = 1'b0;
    for (int i = 0; i < 3 * SFR && !found; i++) begin
      @(negedge clk);
      if (row_s == 10'd20 && col_s == 10'd30) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_find timeout row=%0d col=%0d", row_s, col_s);
    end
    rst_s = 1'b1;
    @(posedge clk);
    #1 rst_s = 1'b0;
    @(negedge clk);
    checks++;
    if (col_s !== 10'd0 || row_s !== 10'd0 || hs_s !== 1'b1 ||
        vs_s !== 1'b1 || fs_s !== 1'b0 || ls_s !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got=%h", obs_s);
    end
    n = 0;
    found = 1'b0;
    while (!found && n < 2 * SFR) begin
      @(negedge clk);
      n++;
      if (fs_s === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found || n != SFR) begin
      errors++;
      $display("FAIL mid_next_fs got=%0d exp=%0d", n, SFR);
    end
  endtask

  task automatic test_random_reset();
    int run, hold;
    for (int k = 0; k < 8; k++) begin
      run = $urandom_range(50, 3 * SFR);
      hold = $urandom_range(1, 3);
      for (int i = 0; i < run; i++) begin
        @(negedge clk);
        checks++;
        if (obs_s !== ms(t_s) || obs_f !== mf(t_f)) begin
          errors++;
          if (errors <= 40)
            $display("FAIL rand t=%0d got=%h/%h exp=%h/%h", t_s,
                     obs_s, obs_f, ms(t_s), mf(t_f));
        end
      end
      rst_s = 1'b1;
      if (k % 3 == 0) rst_f = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_s !== ms(t_s) || obs_f !== mf(t_f)) begin
          errors++;
          $display("FAIL rand_rst got=%h/%h exp=%h/%h",
                   obs_s, obs_f, ms(t_s), mf(t_f));
        end
      end
      rst_s = 1'b0;
      rst_f = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_hline();
    test_frames();
    test_midframe_reset();
    test_random_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
